// File: rtl/fc_dot_requant.sv
// Int8 fully-connected neuron: streams zero-point-corrected act*wgt beats into a
// biased accumulator, then applies optional ReLU and fixed-point requantization.
module fc_dot_requant #(
  parameter int LANES    = 1,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cfg_valid,
  input  logic [LEN_W-1:0]          i_cfg_len,
  input  logic [DATA_W-1:0]         i_cfg_in_zp,
  input  logic [DATA_W-1:0]         i_cfg_w_zp,
  input  logic [DATA_W-1:0]         i_cfg_out_zp,
  input  logic [31:0]               i_cfg_qmult,
  input  logic [7:0]                i_cfg_qshift,
  input  logic                      i_cfg_relu,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [LANES*DATA_W-1:0]   i_act,
  input  logic [LANES*DATA_W-1:0]   i_wgt,
  input  logic [ACC_W-1:0]          i_bias,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_W-1:0]         o_out_data,
  output logic [ACC_W-1:0]          o_out_acc,
  output logic                      o_cfg_loaded
);

  localparam int DIFF_W = 16;
  localparam int PROD_W = 32;
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (DATA_W - 1));

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, SUM, SCALE, OUT} state_t;
  state_t state, state_n;

  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] cfg_in_zp, cfg_w_zp, cfg_out_zp;
  logic [31:0]       cfg_qmult;
  logic [7:0]        cfg_qshift;
  logic              cfg_relu;

  logic [LEN_W-1:0]  beat_cnt;
  logic [ACC_W-1:0]  beat_sum;
  logic              bs_valid;
  logic [ACC_W-1:0]  acc;
  logic signed [63:0] p64;
  logic              scale_done;

  logic              cfg_take, accept, first_beat, last_beat;
  logic [LEN_W-1:0]  eff_len;
  logic [DATA_W-1:0] eff_in_zp, eff_w_zp;

  logic signed [DIFF_W-1:0] lane_a, lane_b;
  logic signed [PROD_W-1:0] lane_p;
  logic [ACC_W-1:0]         lane_sum;

  logic [7:0]         ts;
  logic [ACC_W-1:0]   relu_v;
  logic signed [63:0] mul64, shifted, r_full, r_sat;
  logic [DATA_W-1:0]  req_data;

  // A config presented alongside the first beat must already govern that beat.
  always_comb begin
    cfg_take   = (state == IDLE) && i_cfg_valid;
    eff_len    = cfg_take ? i_cfg_len   : cfg_len;
    eff_in_zp  = cfg_take ? i_cfg_in_zp : cfg_in_zp;
    eff_w_zp   = cfg_take ? i_cfg_w_zp  : cfg_w_zp;
    o_in_ready = ((state == IDLE) && o_cfg_loaded) || (state == ACC);
    accept     = i_in_valid && o_in_ready;
    first_beat = accept && (state == IDLE);
    last_beat  = accept && (((state == IDLE) && (eff_len <= LEN_W'(1))) ||
                            ((state == ACC) && (beat_cnt == cfg_len - LEN_W'(1))));
  end

  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_p   = '0;
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a   = DIFF_W'($signed(i_act[i*DATA_W +: DATA_W])) - DIFF_W'($signed(eff_in_zp));
      lane_b   = DIFF_W'($signed(i_wgt[i*DATA_W +: DATA_W])) - DIFF_W'($signed(eff_w_zp));
      lane_p   = PROD_W'(lane_a) * PROD_W'(lane_b);
      lane_sum = lane_sum + ACC_W'(lane_p);
    end
  end

  // ts = 31 - qshift; the 8-bit modular difference equals ts across its legal range.
  always_comb begin
    ts      = 8'd31 - cfg_qshift;
    relu_v  = (cfg_relu && acc[ACC_W-1]) ? '0 : acc;
    mul64   = 64'($signed(relu_v)) * 64'($signed(cfg_qmult)) + (64'sd1 <<< (ts - 8'd1));
    shifted = p64 >>> ts;
    r_full  = shifted + 64'($signed(cfg_out_zp));
    r_sat   = r_full;
    if (SATURATE != 0) begin
      if (r_full > OUT_MAX)      r_sat = OUT_MAX;
      else if (r_full < OUT_MIN) r_sat = OUT_MIN;
    end
    req_data = DATA_W'(r_sat);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (first_beat) state_n = last_beat ? DRAIN : ACC;
      ACC:     if (last_beat) state_n = DRAIN;
      DRAIN:   state_n = SUM;
      SUM:     state_n = SCALE;
      SCALE:   if (scale_done) state_n = OUT;
      OUT:     if (i_out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cfg_len      <= '0;
      cfg_in_zp    <= '0;
      cfg_w_zp     <= '0;
      cfg_out_zp   <= '0;
      cfg_qmult    <= '0;
      cfg_qshift   <= '0;
      cfg_relu     <= 1'b0;
      o_cfg_loaded <= 1'b0;
      beat_cnt     <= '0;
      beat_sum     <= '0;
      bs_valid     <= 1'b0;
      acc          <= '0;
      p64          <= '0;
      scale_done   <= 1'b0;
      o_out_valid  <= 1'b0;
      o_out_data   <= '0;
      o_out_acc    <= '0;
    end else begin
      state <= state_n;

      if (cfg_take) begin
        cfg_len      <= i_cfg_len;
        cfg_in_zp    <= i_cfg_in_zp;
        cfg_w_zp     <= i_cfg_w_zp;
        cfg_out_zp   <= i_cfg_out_zp;
        cfg_qmult    <= i_cfg_qmult;
        cfg_qshift   <= i_cfg_qshift;
        cfg_relu     <= i_cfg_relu;
        o_cfg_loaded <= (i_cfg_len != '0);
      end

      bs_valid <= accept;
      if (accept) beat_sum <= lane_sum;

      // Beat sums trail acceptance by one cycle, so acc lags the beat stream by two.
      if (first_beat) begin
        acc      <= i_bias;
        beat_cnt <= LEN_W'(1);
      end else begin
        if (bs_valid) acc <= acc + beat_sum;
        if (accept) beat_cnt <= beat_cnt + LEN_W'(1);
      end

      if (state == SCALE) begin
        if (!scale_done) begin
          p64        <= mul64;
          scale_done <= 1'b1;
        end else begin
          scale_done  <= 1'b0;
          o_out_valid <= 1'b1;
          o_out_data  <= req_data;
          o_out_acc   <= acc;
        end
      end

      if ((state == OUT) && i_out_ready) o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_dot_requant.sv
// Scoreboard bench for fc_dot_requant: saturating, truncating and 4-lane instances.
module tb_fc_dot_requant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_w;
  logic        cfg_valid;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_in_zp, cfg_w_zp, cfg_out_zp, cfg_qshift;
  logic [31:0] cfg_qmult;
  logic        cfg_relu;
  logic        in_valid, in_valid_w;
  logic [7:0]  act, wgt;
  logic [31:0] act_w, wgt_w, bias;
  logic        out_ready;

  logic        in_ready0, in_ready1, in_ready_w;
  logic        out_valid0, out_valid1, out_valid_w;
  logic [7:0]  out_data0, out_data1, out_data_w;
  logic [31:0] out_acc0, out_acc1, out_acc_w;
  logic        cfg_loaded0, cfg_loaded1, cfg_loaded_w;

  fc_dot_requant #(.LANES(1), .SATURATE(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_len(cfg_len),
    .i_cfg_in_zp(cfg_in_zp), .i_cfg_w_zp(cfg_w_zp), .i_cfg_out_zp(cfg_out_zp),
    .i_cfg_qmult(cfg_qmult), .i_cfg_qshift(cfg_qshift), .i_cfg_relu(cfg_relu),
    .i_in_valid(in_valid), .o_in_ready(in_ready0), .i_act(act), .i_wgt(wgt),
    .i_bias(bias), .o_out_valid(out_valid0), .i_out_ready(out_ready),
    .o_out_data(out_data0), .o_out_acc(out_acc0), .o_cfg_loaded(cfg_loaded0));

  fc_dot_requant #(.LANES(1), .SATURATE(0)) u_dut_trunc (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_len(cfg_len),
    .i_cfg_in_zp(cfg_in_zp), .i_cfg_w_zp(cfg_w_zp), .i_cfg_out_zp(cfg_out_zp),
    .i_cfg_qmult(cfg_qmult), .i_cfg_qshift(cfg_qshift), .i_cfg_relu(cfg_relu),
    .i_in_valid(in_valid), .o_in_ready(in_ready1), .i_act(act), .i_wgt(wgt),
    .i_bias(bias), .o_out_valid(out_valid1), .i_out_ready(out_ready),
    .o_out_data(out_data1), .o_out_acc(out_acc1), .o_cfg_loaded(cfg_loaded1));

  fc_dot_requant #(.LANES(4), .SATURATE(1)) u_dut_w (
    .i_clk(clk), .i_rst(rst_w), .i_cfg_valid(cfg_valid), .i_cfg_len(cfg_len),
    .i_cfg_in_zp(cfg_in_zp), .i_cfg_w_zp(cfg_w_zp), .i_cfg_out_zp(cfg_out_zp),
    .i_cfg_qmult(cfg_qmult), .i_cfg_qshift(cfg_qshift), .i_cfg_relu(cfg_relu),
    .i_in_valid(in_valid_w), .o_in_ready(in_ready_w), .i_act(act_w), .i_wgt(wgt_w),
    .i_bias(bias), .o_out_valid(out_valid_w), .i_out_ready(out_ready),
    .o_out_data(out_data_w), .o_out_acc(out_acc_w), .o_cfg_loaded(cfg_loaded_w));

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  data;
  } exp_t;

  exp_t q0[$], q1[$], qw[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  int  c_len, c_qmult, c_qshift;
  byte c_in_zp, c_w_zp, c_out_zp;
  bit  c_relu;
  byte acts[$], wgts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] requant(input int acc_v, input bit sat);
    longint rv, p, r;
    int ts;
    rv = (c_relu && acc_v < 0) ? 64'sd0 : longint'(acc_v);
    ts = 31 - c_qshift;
    p  = rv * longint'(c_qmult) + (longint'(1) <<< (ts - 1));
    r  = (p >>> ts) + longint'(c_out_zp);
    if (sat) begin
      if (r > 127)       r = 127;
      else if (r < -128) r = -128;
    end
    return 8'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid0 && out_ready) begin
      if (q0.size() == 0) check("spurious0", 1, 0);
      else begin
        e = q0.pop_front();
        check("data_sat", out_data0, e.data);
        check("acc_sat", out_acc0, e.acc);
      end
    end
    if (!rst && out_valid1 && out_ready) begin
      if (q1.size() == 0) check("spurious1", 1, 0);
      else begin
        e = q1.pop_front();
        check("data_trunc", out_data1, e.data);
        check("acc_trunc", out_acc1, e.acc);
      end
    end
    if (!rst_w && out_valid_w && out_ready) begin
      if (qw.size() == 0) check("spurious_w", 1, 0);
      else begin
        e = qw.pop_front();
        check("data_lanes4", out_data_w, e.data);
        check("acc_lanes4", out_acc_w, e.acc);
      end
    end
  end

  // All driver tasks start and end at posedge+#1.
  task automatic load_cfg(input int len, input byte izp, input byte wzp, input byte ozp,
                          input int qm, input int qs, input bit relu);
    cfg_valid  = 1'b1;
    cfg_len    = 16'(len);
    cfg_in_zp  = izp;
    cfg_w_zp   = wzp;
    cfg_out_zp = ozp;
    cfg_qmult  = qm;
    cfg_qshift = 8'(qs);
    cfg_relu   = relu;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    c_len = len; c_in_zp = izp; c_w_zp = wzp; c_out_zp = ozp;
    c_qmult = qm; c_qshift = qs; c_relu = relu;
    check("cfg_loaded", cfg_loaded0, (len != 0));
  endtask

  task automatic send_dot(input int bias_v);
    exp_t e;
    int acc_v;
    int n;
    acc_v = bias_v;
    for (int i = 0; i < c_len; i++)
      acc_v += (int'(acts[i]) - int'(c_in_zp)) * (int'(wgts[i]) - int'(c_w_zp));
    e.acc  = acc_v;
    e.data = requant(acc_v, 1'b1);
    q0.push_back(e);
    e.data = requant(acc_v, 1'b0);
    q1.push_back(e);
    bias = bias_v;
    for (int i = 0; i < c_len; i++) begin
      in_valid = 1'b1;
      act = acts[i];
      wgt = wgts[i];
      n = 0;
      while (!in_ready0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 50) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_w(input int n_beats, input byte a, input byte w, input int bias_v);
    exp_t e;
    int acc_v;
    int n;
    acc_v  = bias_v + n_beats * 4 * ((int'(a) - int'(c_in_zp)) * (int'(w) - int'(c_w_zp)));
    e.acc  = acc_v;
    e.data = requant(acc_v, 1'b1);
    qw.push_back(e);
    bias = bias_v;
    for (int i = 0; i < n_beats; i++) begin
      in_valid_w = 1'b1;
      act_w = {4{a}};
      wgt_w = {4{w}};
      n = 0;
      while (!in_ready_w && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 50) check("in_ready_w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid_w = 1'b0;
  endtask

  task automatic wait_out(input bit lanes4);
    int n;
    n = 0;
    @(negedge clk);
    while (!(lanes4 ? out_valid_w : out_valid0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("out_timeout", 0, 1);
    else if (!lanes4) check("latency", cyc - acc_cyc, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    cfg_valid = 1'b0; cfg_len = '0; cfg_in_zp = '0; cfg_w_zp = '0; cfg_out_zp = '0;
    cfg_qmult = '0; cfg_qshift = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_valid_w = 1'b0; act = '0; wgt = '0; act_w = '0; wgt_w = '0;
    bias = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_acc", out_acc0, 0);
    check("rst_cfg_loaded", cfg_loaded0, 0);
    rst = 1'b0; rst_w = 1'b0;
    @(posedge clk); #1;

    load_cfg(0, 0, 0, 0, 32'h4000_0000, 0, 0);
    check("len0_in_ready", in_ready0, 0);

    load_cfg(3, 0, 0, 0, 32'h4000_0000, 0, 0);
    acts = '{1, 2, 3}; wgts = '{4, 5, 6};
    send_dot(10); wait_out(0);

    load_cfg(3, 8'sh80, 0, 0, 32'h4000_0000, 0, 0);
    acts = '{8'sh80, 8'sh80, 8'sh80}; wgts = '{7, 7, 7};
    send_dot(5); wait_out(0);

    load_cfg(3, 0, 7, 0, 32'h4000_0000, 0, 0);
    acts = '{2, 2, 2}; wgts = '{7, 7, 7};
    send_dot(5); wait_out(0);

    load_cfg(1, 0, 0, 8'shFB, 32'h4000_0000, 0, 1);
    acts = '{0}; wgts = '{0};
    send_dot(-100); wait_out(0);
    load_cfg(1, 0, 0, 8'shFB, 32'h4000_0000, 0, 0);
    send_dot(-100); wait_out(0);

    load_cfg(1, 0, 0, 0, 32'h4000_0000, 0, 0);
    send_dot(1000); wait_out(0);

    // Backpressure: result must hold and config pulses must be ignored.
    load_cfg(3, 0, 0, 0, 32'h4000_0000, 0, 0);
    acts = '{1, 2, 3}; wgts = '{4, 5, 6};
    out_ready = 1'b0;
    send_dot(10); wait_out(0);
    for (int k = 0; k < 5; k++) begin
      cfg_valid = k[0]; cfg_len = 16'd1; cfg_out_zp = 8'h55; cfg_qmult = '0;
      @(negedge clk);
      check("hold_data", out_data0, q0[0].data);
      check("hold_acc", out_acc0, q0[0].acc);
      check("hold_valid", out_valid0, 1);
      check("hold_in_ready", in_ready0, 0);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready0, 1);
    acts = '{-1, -2, -3};
    send_dot(10); wait_out(0);

    for (int r = 0; r < 6; r++) begin
      load_cfg(int'($urandom_range(5, 1)), byte'($urandom), byte'($urandom),
               byte'(int'($urandom_range(40, 0)) - 20),
               int'($urandom_range(32'h7FFF_FFFF, 32'h1000_0000)),
               int'($urandom_range(8, 0)) - 4, bit'($urandom_range(1, 0)));
      acts.delete(); wgts.delete();
      for (int i = 0; i < c_len; i++) begin
        acts.push_back(byte'($urandom));
        wgts.push_back(byte'($urandom));
      end
      send_dot(int'($urandom_range(6000, 0)) - 3000);
      wait_out(0);
    end

    load_cfg(2, 0, 0, 0, 32'h4000_0000, 0, 0);
    send_w(2, 1, 1, 0); wait_out(1);

    // Reset after the first beat discards the dot product and the config.
    in_valid_w = 1'b1; act_w = 32'h0101_0101; wgt_w = 32'h0101_0101;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    rst_w = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid_w, 0);
    check("mid_rst_in_ready", in_ready_w, 0);
    check("mid_rst_cfg_loaded", cfg_loaded_w, 0);
    check("mid_rst_out_data", out_data_w, 0);
    check("mid_rst_out_acc", out_acc_w, 0);
    @(posedge clk); #1;
    rst_w = 1'b0;
    in_valid_w = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_no_out", out_valid_w, 0);
      check("post_rst_in_ready", in_ready_w, 0);
      @(posedge clk); #1;
    end
    in_valid_w = 1'b0;

    load_cfg(2, 0, 0, 0, 32'h4000_0000, 0, 0);
    send_w(2, 2, -1, 3); wait_out(1);

    repeat (5) @(posedge clk);
    #1;
    check("q_sat_empty", q0.size(), 0);
    check("q_trunc_empty", q1.size(), 0);
    check("q_lanes4_empty", qw.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fc_dot_requant.md
Name: fc_dot_requant

Overview:
Sequential int8 fully-connected neuron engine. It streams activation/weight beats of LANES elements each, subtracts zero points, multiplies and accumulates with bias, and applies optional ReLU. It then requantizes to int8 using a fixed-point multiplier and rounding shift. The block is the synthesizable successor of the MNIST dense-layer flow; one dot product yields one output neuron, with valid/ready handshakes on both sides.

Parameters:
LANES, 1, activation/weight element pairs consumed per beat
DATA_W, 8, activation/weight/zero-point/output width (signed)
ACC_W, 32, accumulator and bias width (signed)
LEN_W, 16, width of beat-count config
SATURATE, 1, 1 = clamp output to signed DATA_W range; 0 = truncate to low DATA_W bits

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_cfg_valid  in  1  load config (honoured only in IDLE)
i_cfg_len  in  LEN_W  beats per dot product
i_cfg_in_zp  in  DATA_W  activation zero point
i_cfg_w_zp  in  DATA_W  weight zero point
i_cfg_out_zp  in  DATA_W  output zero point
i_cfg_qmult  in  32  signed quant multiplier
i_cfg_qshift  in  8  signed quant shift
i_cfg_relu  in  1  1 = ReLU on accumulator
i_in_valid  in  1  beat valid
o_in_ready  out  1  beat accept
i_act  in  LANES*DATA_W  packed activations, lane 0 in LSBs
i_wgt  in  LANES*DATA_W  packed weights, lane 0 in LSBs
i_bias  in  ACC_W  bias; sampled on first beat only
o_out_valid  out  1  result valid
i_out_ready  in  1  result accept
o_out_data  out  DATA_W  requantized neuron output
o_out_acc  out  ACC_W  post-bias, pre-ReLU accumulator (debug)
o_cfg_loaded  out  1  config register valid

Behaviour:
- Reset (async): state IDLE. o_in_ready=0, o_out_valid=0, o_out_data=0, o_out_acc=0, o_cfg_loaded=0. All counters and pipeline registers are cleared. A reset mid-operation discards the partial dot product and the config.
- States: IDLE, ACC, DRAIN, SUM, SCALE, OUT.
- Config: captured on i_cfg_valid in IDLE and sets o_cfg_loaded. It persists across dot products. i_cfg_valid outside IDLE is ignored. i_cfg_len=0 leaves o_cfg_loaded=0.
- o_in_ready=1 only in IDLE with o_cfg_loaded=1, or in ACC. The beat handshake is i_in_valid&&o_in_ready.
- First beat (IDLE): acc<=i_bias, beat_cnt<=1. Next state is ACC, or DRAIN if cfg_len==1.
- ACC: each beat increments beat_cnt. The beat with beat_cnt==cfg_len-1 moves to DRAIN.
- Per lane: a=act-in_zp and b=wgt-w_zp, each sign-extended to 16 bits. The product is 32-bit signed. Lane products are summed into beat_sum, registered one cycle after acceptance.
- beat_sum is added to acc the cycle after it registers. acc wraps modulo 2^ACC_W with no saturation.
- DRAIN: 1 cycle, last beat_sum registered. SUM: 1 cycle, final acc formed.
- SCALE:
  - relu_v = (cfg_relu && acc<0) ? 0 : acc.
  - ts = 31-qshift; legal range 1..62, otherwise undefined.
  - p64 = relu_v*qmult + (1<<(ts-1)), registered.
- OUT entry:
  - r = (p64 >>> ts) + out_zp, using an arithmetic shift.
  - Output is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when SATURATE=1, otherwise the low DATA_W bits.
  - o_out_valid=1, and o_out_acc=acc.
- Latency: o_out_valid rises 4 clock edges after the last-beat acceptance edge.
- OUT: o_out_data and o_out_acc are held stable until i_out_ready. On handshake: o_out_valid=0, next state IDLE. The next first beat is accepted no earlier than the following cycle.
- Simultaneous i_cfg_valid and first beat in IDLE: the new config applies to that beat, and to cfg_len, zero points and requant of that dot product.

Test Plan:
- LANES=1, zps 0, len 3, act{1,2,3}, wgt{4,5,6}, bias 10, qmult 0x40000000, qshift 0, out_zp 0 -> acc 42, o_out_data 21, o_out_valid 4 edges after 3rd beat.
- in_zp 0x80, act all 0x80, wgt 7, bias 5, same quant -> acc 5, o_out_data 3; w_zp 7 with act 2 -> acc=bias.
- relu=1, acc -100, out_zp 0xFB -> o_out_data 0xFB, o_out_acc -100; relu=0 -> (-100*2^30+2^30)>>>31 = -50, o_out_data -55 (0xC9).
- acc 1000, qmult 2^30, qshift 0 -> SATURATE=1 gives 127 (0x7F); SATURATE=0 gives 500 mod 256 = 0xF4.
- Backpressure: i_out_ready low 5 cycles -> o_out_data stable, o_in_ready 0, i_cfg_valid pulses ignored; release -> IDLE, next dot product correct.
- LANES=4, len 2, all act 1/wgt 1, bias 0 -> acc 8, o_out_data 4. i_rst pulsed after 1st beat -> all outputs 0, o_cfg_loaded 0, no o_out_valid.
